score_display: RTL and testbench

- Parametrised multi-digit seven-segment driver for the score and combo readouts on the board HEX displays.
- Accepts a binary value and converts it to BCD sequentially using shift-and-add-3 (double-dabble), one bit per clock.
- Encodes the digits to active-low segment patterns and holds them stable until the next load.
- Also supports a hexadecimal debug mode, leading-zero blanking and overflow indication. It replaces per-digit decoder instances in the top level.

---
 rtl/score_display_pkg.sv | 22 ++
 rtl/score_display_seg_glyph.sv | 21 ++
 rtl/score_display.sv | 156 +++++++++++++++
 tb/tb_score_display.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared definitions for the score_display seven-segment driver:
// FSM state encoding and active-low glyph constants (bit 6 = g, bit 0 = a).
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n holds the glyph for nibble value n.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E D C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // B A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

endpackage

// File: rtl/score_display_seg_glyph.sv
// Combinational nibble-to-segment decoder; dash overrides blank, blank overrides the digit.
module seg_glyph
  import score_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = HEX_GLYPH[digit];
    end
  end

endmodule

// File: rtl/score_display.sv
// Multi-digit seven-segment driver: sequential double-dabble binary-to-BCD
// (one bit per clock) or direct hex, with leading-zero blanking and overflow dashes.
module score_display
  import score_display_pkg::*;
#(
  parameter int BIN_WIDTH     = 20,
  parameter int NUM_DIGITS    = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  input  logic                    hex_mode,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output state_e                  state_dbg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int EXT_W = (BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W;

  // Handshake: load is a request sampled only in IDLE; busy is high from the
  // accepting edge until the edge that writes seg_out. Loads while busy are dropped.
  state_e                  state_q, state_d;
  logic [BIN_WIDTH-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    mode_q, mode_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_shifted;
  logic                    bcd_carry;
  logic [EXT_W-1:0]        hex_ext;
  logic                    hex_ovf;
  logic [BCD_W-1:0]        disp_digits;
  logic                    disp_ovf;
  logic [NUM_DIGITS-1:0]   blank;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    zero_run;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next input bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shifted = {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    bcd_carry   = bcd_adj[BCD_W-1];
  end

  always_comb begin
    hex_ext                  = '0;
    hex_ext[BIN_WIDTH-1:0]   = shift_q;
    hex_ovf                  = 1'b0;
    for (int i = BCD_W; i < EXT_W; i++) begin
      hex_ovf = hex_ovf | hex_ext[i];
    end
    disp_digits = mode_q ? hex_ext[BCD_W-1:0] : bcd_q;
    disp_ovf    = mode_q ? hex_ovf : ovf_q;
    zero_run    = 1'b1;
    blank       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_digits[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LEADING != 0) && (k != 0) && zero_run;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
    seg_glyph u_glyph (
      .digit (disp_digits[4*g +: 4]),
      .blank (blank[g]),
      .dash  (disp_ovf),
      .seg   (seg_next[7*g +: 7])
    );
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    seg_d      = seg_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = value;
          mode_d  = hex_mode;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = hex_mode ? UPDATE : CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = bcd_shifted;
        shift_d = shift_q << 1;
        ovf_d   = ovf_q | bcd_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        seg_d      = seg_next;
        overflow_d = disp_ovf;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      seg_q      <= '1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
    end
  end

  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign seg_out   = seg_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display at default parameters: directed cases
// plus randomized loads compared against an arithmetic reference model.
module tb_score_display;
  import score_display_pkg::*;

  localparam int BW = 20;
  localparam int ND = 6;
  localparam int SW = 7 * ND;

  logic          clk;
  logic          resetn;
  logic [BW-1:0] value;
  logic          load;
  logic          hex_mode;
  logic          busy;
  logic          overflow;
  logic [SW-1:0] seg_out;
  state_e        state_dbg;

  score_display #(.BIN_WIDTH(BW), .NUM_DIGITS(ND), .BLANK_LEADING(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .value     (value),
    .load      (load),
    .hex_mode  (hex_mode),
    .busy      (busy),
    .overflow  (overflow),
    .seg_out   (seg_out),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [SW:0] exp_q[$];   // {overflow, seg_out}
  int          busy_cnt;
  bit          glitch;
  logic [SW-1:0] held_seg;
  logic          held_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model, straight from the glyph table and decimal/hex arithmetic.
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
          7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  function automatic logic [SW:0] model(input int unsigned v, input bit h);
    int unsigned digs [ND];
    longint unsigned p;
    bit ovf;
    bit leading;
    logic [SW-1:0] s;
    p = 1;
    for (int k = 0; k < ND; k++) begin
      digs[k] = h ? ((v >> (4 * k)) & 15) : ((v / p) % 10);
      p = p * 10;
    end
    ovf = h ? ((longint'(v) >> (4 * ND)) != 0) : (longint'(v) >= p);
    leading = 1'b1;
    s = '1;
    for (int k = ND - 1; k >= 0; k--) begin
      if (digs[k] != 0) leading = 1'b0;
      if (ovf) s[7*k +: 7] = 7'b0111111;
      else if (leading && k != 0) s[7*k +: 7] = 7'b1111111;
      else s[7*k +: 7] = glyph(int'(digs[k]));
    end
    return {ovf, s};
  endfunction

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    if (busy) begin
      busy_cnt++;
      if (seg_out !== held_seg || overflow !== held_ovf) glitch = 1'b1;
    end
  endtask

  task automatic arm(input int unsigned v, input bit h, input bit push);
    value    = BW'(v);
    hex_mode = h;
    held_seg = seg_out;
    held_ovf = overflow;
    glitch   = 1'b0;
    busy_cnt = 0;
    if (push) exp_q.push_back(model(v, h));
  endtask

  task automatic start_load(input int unsigned v, input bit h, input bit push);
    arm(v, h, push);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    logic [SW:0] e;
    int guard = 0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    if (busy) check({tag, "_timeout"}, 64'd1, 64'd0);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_cycles));
    check({tag, "_stable"}, 64'(glitch), 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_seg"}, 64'(seg_out), 64'(e[SW-1:0]));
      check({tag, "_ovf"}, 64'(overflow), 64'(e[SW]));
    end
  endtask

  task automatic run_one(input string tag, input int unsigned v, input bit h);
    start_load(v, h, 1'b1);
    wait_done(tag, h ? 1 : BW + 1);
  endtask

  initial begin
    int unsigned v;
    resetn = 1'b0; load = 1'b0; value = '0; hex_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", 64'(seg_out), {{(64-SW){1'b0}}, {SW{1'b1}}});
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    resetn = 1'b1;
    @(negedge clk);

    run_one("zero", 0, 1'b0);
    run_one("d1234", 1234, 1'b0);
    run_one("d999999", 999999, 1'b0);
    run_one("d1000000", 1000000, 1'b0);
    run_one("hexABC", 32'hABC, 1'b1);
    run_one("hexmax", 32'hFFFFF, 1'b1);

    // Load while busy is dropped
    start_load(555, 1'b0, 1'b1);
    repeat (3) tick();
    value = BW'(777); load = 1'b1;
    tick();
    load = 1'b0;
    wait_done("ignore", BW + 1);

    // Load held high retriggers only once back in IDLE
    arm(321, 1'b0, 1'b1);
    load = 1'b1;
    tick();
    value = BW'(654);
    wait_done("held1", BW + 1);
    arm(654, 1'b0, 1'b1);
    tick();
    load = 1'b0;
    wait_done("held2", BW + 1);

    // Reset mid-conversion
    start_load(123456, 1'b0, 1'b0);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    check("midrst_seg", 64'(seg_out), {{(64-SW){1'b0}}, {SW{1'b1}}});
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_one("after_rst42", 42, 1'b0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(999990, 1000010);
        2:       v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, (1 << BW) - 1);
      endcase
      run_one("rand", v, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
